// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C target core.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_DATA  = 3'd3,
        WR_ACK   = 3'd4,
        RD_DATA  = 3'd5,
        RD_ACK   = 3'd6,
        IGNORE   = 3'd7
    } i2c_state_t;

    localparam logic I2C_RW_READ = 1'b1;
    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into clk and derives SCL edges plus START/STOP conditions.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_ff, sda_ff;
    logic                   scl_d, sda_d;
    logic                   scl_s;

    // Reset to the idle-bus level so no edge is seen when reset releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_ff <= '1;
            sda_ff <= '1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl_i};
            sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_i};
            scl_d  <= scl_s;
            sda_d  <= sda_s;
        end
    end

    assign scl_s     = scl_ff[SYNC_STAGES-1];
    assign sda_s     = sda_ff[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_d;
    assign scl_fall  = ~scl_s &  scl_d;
    assign start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
    assign stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_target_core.sv
// I2C target with fixed 7-bit address: parallel byte out on writes, valid/ready
// byte source on reads. No clock stretching.
module i2c_target_core
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h21,
    parameter int         SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       sda_o,
    input  logic [7:0] data_i,
    input  logic       data_i_valid,
    output logic       data_i_ready,
    output logic [7:0] data_o,
    output logic       data_o_valid
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    i2c_state_t state, state_nxt;
    logic [3:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shift_q, shift_nxt;
    logic [7:0] tx_q, tx_nxt;
    logic [7:0] data_q, data_nxt;
    logic [7:0] tx_byte;
    logic       sda_q, sda_nxt;
    logic       rw_q, rw_nxt;
    logic       dov_nxt;
    logic       load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift_q      <= '0;
            tx_q         <= '1;
            data_q       <= '0;
            sda_q        <= 1'b1;
            rw_q         <= 1'b0;
            data_o_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            shift_q      <= shift_nxt;
            tx_q         <= tx_nxt;
            data_q       <= data_nxt;
            sda_q        <= sda_nxt;
            rw_q         <= rw_nxt;
            data_o_valid <= dov_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_q;
        tx_nxt      = tx_q;
        data_nxt    = data_q;
        sda_nxt     = sda_q;
        rw_nxt      = rw_q;
        dov_nxt     = 1'b0;
        load        = 1'b0;
        tx_byte     = 8'hFF;

        if (start_det) begin
            state_nxt   = ADDR;
            bit_cnt_nxt = '0;
            sda_nxt     = 1'b1;
        end else if (stop_det) begin
            state_nxt = IDLE;
            sda_nxt   = 1'b1;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shift_nxt   = {shift_q[6:0], sda_s};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_nxt = '0;
                        if (shift_q[7:1] == SLAVE_ADDRESS) begin
                            sda_nxt   = I2C_ACK;
                            rw_nxt    = shift_q[0];
                            state_nxt = ADDR_ACK;
                        end else begin
                            state_nxt = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q == I2C_RW_READ) begin
                            load      = 1'b1;
                            state_nxt = RD_DATA;
                        end else begin
                            sda_nxt   = 1'b1;
                            state_nxt = WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shift_nxt   = {shift_q[6:0], sda_s};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            data_nxt = {shift_q[6:0], sda_s};
                            dov_nxt  = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_nxt = '0;
                        sda_nxt     = I2C_ACK;
                        state_nxt   = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_nxt   = 1'b1;
                        state_nxt = WR_DATA;
                    end
                end
                RD_DATA: begin
                    // bit_cnt counts bits already placed on the bus
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt_nxt = '0;
                            sda_nxt     = 1'b1;
                            state_nxt   = RD_ACK;
                        end else begin
                            sda_nxt     = tx_q[7];
                            tx_nxt      = {tx_q[6:0], 1'b1};
                            bit_cnt_nxt = bit_cnt + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    // A fall reached here means the preceding rise carried an ACK.
                    if (scl_rise && sda_s == I2C_NACK) begin
                        state_nxt = IGNORE;
                    end else if (scl_fall) begin
                        load      = 1'b1;
                        state_nxt = RD_DATA;
                    end
                end
                default: ;
            endcase
        end

        if (load) begin
            tx_byte     = data_i_valid ? data_i : 8'hFF;
            sda_nxt     = tx_byte[7];
            tx_nxt      = {tx_byte[6:0], 1'b1};
            bit_cnt_nxt = 4'd1;
        end
    end

    assign data_i_ready = load & data_i_valid;
    assign data_o       = data_q;
    assign sda_o        = sda_q;
    assign scl_o        = 1'b1;

endmodule

// File: tb/tb_i2c_target_core.sv
// Bit-level I2C master driving the target over a wired-AND bus, with scoreboards
// for written bytes and read-back bytes.
module tb_i2c_target_core;
    import i2c_pkg::*;

    localparam int Q = 10;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_m, sda_m;
    logic       scl_o, sda_o;
    logic       scl_i, sda_i;
    logic [7:0] data_i;
    logic       data_i_valid;
    logic       data_i_ready;
    logic [7:0] data_o;
    logic       data_o_valid;

    assign scl_i = scl_m & scl_o;
    assign sda_i = sda_m & sda_o;

    i2c_target_core #(.SLAVE_ADDRESS(7'h21), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scl_i       (scl_i),
        .sda_i       (sda_i),
        .scl_o       (scl_o),
        .sda_o       (sda_o),
        .data_i      (data_i),
        .data_i_valid(data_i_valid),
        .data_i_ready(data_i_ready),
        .data_o      (data_o),
        .data_o_valid(data_o_valid)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboards
    logic [7:0] wr_q[$];
    logic [7:0] rd_q[$];

    logic [7:0] src[4];
    int         src_idx  = 0;
    bit         src_adv  = 0;
    int         rdy_cnt  = 0;
    int         dov_cnt  = 0;
    bit         dov_prev = 0;
    bit         sda_low_seen = 0;

    always @(negedge clk) begin
        if (src_adv) begin
            src_adv = 0;
            src_idx++;
            if (src_idx < 4) data_i = src[src_idx];
        end
        if (data_i_ready) begin
            rdy_cnt++;
            src_adv = 1;
        end
        if (sda_o == 1'b0) sda_low_seen = 1;
        if (data_o_valid) begin
            dov_cnt++;
            if (dov_prev) chk("dov_single_cycle", 1, 0);
            if (wr_q.size() == 0) chk("dov_unexpected", 1, 0);
            else chk("data_o", {24'h0, data_o}, {24'h0, wr_q.pop_front()});
        end
        dov_prev = data_o_valid;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic m_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic m_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    wait_clk(Q);
        scl_m = 1'b1; wait_clk(2*Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        @(negedge clk) b = sda_i;
        wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic m_ack);
        logic bt;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bt);
            b[i] = bt;
        end
        write_bit(m_ack);
    endtask

    logic       ack;
    logic [7:0] rb;
    int         base;

    initial begin
        scl_m = 1'b1; sda_m = 1'b1;
        rst_n = 1'b0; data_i = 8'h00; data_i_valid = 1'b0;
        wait_clk(5);
        @(negedge clk);
        chk("rst_scl_o", scl_o, 1);
        chk("rst_sda_o", sda_o, 1);
        chk("rst_data_o", data_o, 0);
        chk("rst_dov", data_o_valid, 0);
        chk("rst_ready", data_i_ready, 0);
        chk("rst_state", dut.state, IDLE);
        rst_n = 1'b1;
        wait_clk(5);

        // single byte write
        m_start();
        write_byte(8'h42, ack); chk("t1_addr_ack", ack, 0);
        wr_q.push_back(8'h5A);
        write_byte(8'h5A, ack); chk("t1_data_ack", ack, 0);
        m_stop(); wait_clk(4);
        @(negedge clk);
        chk("t1_idle", dut.state, IDLE);
        chk("t1_data_o", data_o, 8'h5A);

        // four byte write
        begin
            logic [7:0] wv[4];
            wv = '{8'h83, 8'h72, 8'hA5, 8'h23};
            base = dov_cnt;
            m_start();
            write_byte(8'h42, ack); chk("t2_addr_ack", ack, 0);
            for (int i = 0; i < 4; i++) begin
                wr_q.push_back(wv[i]);
                write_byte(wv[i], ack); chk("t2_data_ack", ack, 0);
            end
            m_stop(); wait_clk(4);
            chk("t2_pulses", dov_cnt - base, 4);
        end

        // address mismatch, then a matching transfer
        sda_low_seen = 0;
        base = dov_cnt;
        m_start();
        write_byte(8'h44, ack); chk("t3_addr_nack", ack, 1);
        write_byte(8'h5A, ack); chk("t3_data_nack", ack, 1);
        m_stop(); wait_clk(4);
        chk("t3_sda_never_low", sda_low_seen, 0);
        chk("t3_no_dov", dov_cnt - base, 0);
        m_start();
        write_byte(8'h42, ack); chk("t3_next_addr_ack", ack, 0);
        wr_q.push_back(8'h11);
        write_byte(8'h11, ack); chk("t3_next_data_ack", ack, 0);
        m_stop(); wait_clk(4);

        // four byte read, last one NACKed
        src = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};
        src_idx = 0; data_i = src[0]; data_i_valid = 1'b1;
        for (int i = 0; i < 4; i++) rd_q.push_back(src[i]);
        base = rdy_cnt;
        m_start();
        write_byte(8'h43, ack); chk("t4_addr_ack", ack, 0);
        for (int i = 0; i < 4; i++) begin
            read_byte(rb, (i == 3) ? 1'b1 : 1'b0);
            chk("t4_rd_byte", rb, rd_q.pop_front());
        end
        @(negedge clk);
        chk("t4_sda_released", sda_o, 1);
        chk("t4_ignore", dut.state, IGNORE);
        m_stop(); wait_clk(4);
        @(negedge clk);
        chk("t4_idle", dut.state, IDLE);
        chk("t4_ready_pulses", rdy_cnt - base, 4);
        data_i_valid = 1'b0;

        // read with empty source
        base = rdy_cnt;
        rd_q.push_back(8'hFF);
        m_start();
        write_byte(8'h43, ack); chk("t5_addr_ack", ack, 0);
        read_byte(rb, 1'b1);
        chk("t5_rd_empty", rb, rd_q.pop_front());
        m_stop(); wait_clk(4);
        chk("t5_no_ready", rdy_cnt - base, 0);

        // repeated START discards a partial byte
        base = dov_cnt;
        m_start();
        write_byte(8'h42, ack); chk("t6_addr_ack", ack, 0);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        m_start();
        write_byte(8'h42, ack); chk("t6_rs_addr_ack", ack, 0);
        wr_q.push_back(8'h33);
        write_byte(8'h33, ack); chk("t6_data_ack", ack, 0);
        m_stop(); wait_clk(4);
        chk("t6_one_pulse", dov_cnt - base, 1);
        chk("t6_data_o", data_o, 8'h33);

        // asynchronous reset while the DUT holds an address ACK
        m_start();
        for (int i = 7; i >= 0; i--) write_bit(i == 0 ? 1'b0 : ((8'h42 >> i) & 1) != 0);
        @(negedge clk);
        chk("t7_ack_driven", sda_o, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_sda_o", sda_o, 1);
        chk("t7_rst_data_o", data_o, 0);
        chk("t7_rst_dov", data_o_valid, 0);
        chk("t7_rst_ready", data_i_ready, 0);
        chk("t7_rst_state", dut.state, IDLE);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        rst_n = 1'b1; wait_clk(Q);

        chk("wr_scoreboard_empty", wr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_target_core.md
Name: i2c_target_core

Overview:
- Synthesizable I2C slave (target) with a fixed 7-bit address, sampling the bus in the system clock domain.
- Write transfers: each received byte is presented on a parallel output with a one-cycle valid strobe.
- Read transfers: bytes are fetched from a valid/ready source and shifted out MSB first.
- Sits between the open-drain pad logic (wired-AND SCL/SDA) and user logic.

Parameters:
- SLAVE_ADDRESS, 7'h21, 7-bit bus address this target responds to.
- SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i (minimum 2).

Ports:
- clk  in  1  system clock; SCL must be at least 8x slower.
- rst_n  in  1  asynchronous, active-low reset.
- scl_i  in  1  resolved bus SCL.
- sda_i  in  1  resolved bus SDA.
- scl_o  out  1  SCL pull-down: 0 drives low, 1 releases.
- sda_o  out  1  SDA pull-down: 0 drives low, 1 releases.
- data_i  in  8  byte to transmit on reads.
- data_i_valid  in  1  data_i holds a valid byte.
- data_i_ready  out  1  one-cycle pulse: data_i consumed this cycle.
- data_o  out  8  last byte received on a write.
- data_o_valid  out  1  one-cycle pulse: data_o updated.

Behaviour:
- Reset values: scl_o=1, sda_o=1, data_o=8'h00, data_o_valid=0, data_i_ready=0, state IDLE.
- Reset is asynchronous and takes effect even in the middle of a transfer.
- No clock stretching: scl_o is held at 1 permanently.
- scl_i and sda_i pass through SYNC_STAGES flops before use.
- Edge detection on the synchronized signals gives scl_rise, scl_fall, START and STOP.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- START or STOP is recognized from any state, overrides everything else, and releases sda_o in the same cycle.
  - START, including a repeated START, goes to ADDR with the bit counter cleared.
  - STOP goes to IDLE.
- Data bits are sampled on scl_rise. sda_o changes only on scl_fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits (7 address bits, then R/W).
    - Address match: on the 8th scl_fall, drive sda_o=0 and go to ADDR_ACK.
    - Mismatch: go to IGNORE and never drive sda_o.
  - ADDR_ACK: on the next scl_fall, release SDA.
    - R/W=0: go to WR_DATA.
    - R/W=1: go to RD_DATA and load the transmit byte (rule below); sda_o = bit 7 on that same fall.
  - WR_DATA: shift in 8 bits.
    - On the 8th scl_rise, data_o takes the byte and data_o_valid pulses for exactly one clk cycle.
    - On the 8th scl_fall, drive ACK (sda_o=0) and go to WR_ACK.
  - WR_ACK: on the next scl_fall, release SDA and return to WR_DATA.
  - RD_DATA: on each scl_fall, drive the next bit, MSB first.
    - After the 8th bit's scl_fall, release SDA and go to RD_ACK.
  - RD_ACK: sample the master's acknowledge on scl_rise.
    - ACK (0): on the next scl_fall, load a new byte and drive its bit 7; go to RD_DATA.
    - NACK (1): go to IGNORE with SDA released.
  - IGNORE: SDA released; wait for START or STOP.
- Transmit byte load rule:
  - If data_i_valid=1 at the load cycle: latch data_i and pulse data_i_ready for exactly one cycle.
  - Otherwise: send 8'hFF and do not pulse ready.
- Writes never stall; data_o is overwritten on every byte.
- A STOP or START in the middle of a byte discards the partial byte: no data_o_valid pulse.
- data_o keeps its last value when idle.

Decomposition:
- Package i2c_pkg holds:
  - state enum (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE);
  - constants I2C_RW_READ=1, I2C_ACK=0, I2C_NACK=1.
- One sub-module, i2c_line_sync: synchronizes scl_i/sda_i and outputs scl_rise, scl_fall, start_det, stop_det.

Test Plan:
- Write 1 byte to 0x21, data 0x5A -> ACK on address and data; one data_o_valid pulse with data_o=0x5A; IDLE after STOP.
- Write 4 bytes 0x83,0x72,0xA5,0x23 -> four ACKs; four single-cycle data_o_valid pulses in that order.
- Address 0x22 write with 0x5A -> SDA never pulled low by the DUT; no data_o_valid; DUT still responds to a following transfer to 0x21.
- Read 4 bytes from 0x21, source supplying 0xA5,0x5A,0x3C,0xC3 (master ACKs 3 bytes, NACKs the last) -> master receives A5,5A,3C,C3; exactly 4 data_i_ready pulses; SDA released after the NACK; STOP returns the DUT to IDLE.
- Read with data_i_valid=0 -> byte 0xFF returned; no data_i_ready pulse.
- Repeated START after a partial write byte, then a new write of 0x33 -> partial byte discarded; data_o=0x33. A separate run asserts rst_n low in the middle of a transfer -> all outputs return to reset values at once.
